seq_divider_16by8: RTL and testbench

- Iterative unsigned restoring divider: 16-bit dividend by 8-bit divisor.
- Inverse operator of the 8x8 product path in the DCIM multiplier. It recovers an operand, or rescales an accumulated product, from a 16-bit product word.
- Sits behind the multiplier/accumulator output, with valid/ready handshakes on both sides.
- Produces one quotient bit per clock.

---
 rtl/seq_divider_16by8.sv | 129 ++++++++++++
 tb/tb_seq_divider_16by8.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_16by8.sv
// Iterative unsigned restoring divider: DW-bit dividend by VW-bit divisor, one quotient bit per clock.
// Operands enter through a valid/ready handshake and results leave through another.
module seq_divider_16by8 #(
  parameter int DW = 16,
  parameter int VW = 8,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] d_q, d_d;
  logic [VW-1:0] r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbz_q, dbz_d;

  logic          accept;
  logic [VW:0]   trial;
  logic [VW:0]   diff;
  logic          fits;

  assign accept = in_valid && (state_q == IDLE);

  // The stored remainder is always below D, so it fits in VW bits; the guard bit
  // is carried by the VW+1-bit trial value where the compare/subtract happens.
  assign trial = {r_q, q_q[DW-1]};
  assign diff  = trial - {1'b0, d_q};
  assign fits  = (trial >= {1'b0, d_q});

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (divisor == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready    = (state_q == IDLE);
    busy        = (state_q == BUSY);
    out_valid   = (state_q == DONE);
    quotient    = q_q;
    remainder   = r_q;
    div_by_zero = dbz_q;
  end

  // Datapath next values
  always_comb begin
    q_d   = q_q;
    d_d   = d_q;
    r_d   = r_q;
    cnt_d = cnt_q;
    dbz_d = dbz_q;
    if (accept) begin
      d_d = divisor;
      if (divisor == '0) begin
        q_d   = '1;
        r_d   = dividend[VW-1:0];
        cnt_d = '0;
        dbz_d = 1'b1;
      end else begin
        q_d   = dividend;
        r_d   = '0;
        cnt_d = CW'(DW);
        dbz_d = 1'b0;
      end
    end else if (state_q == BUSY) begin
      r_d   = fits ? diff[VW-1:0] : trial[VW-1:0];
      q_d   = {q_q[DW-2:0], fits};
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      d_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      d_q   <= d_d;
      r_q   <= r_d;
      cnt_q <= cnt_d;
      dbz_q <= dbz_d;
    end
  end

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Directed and randomised checks of seq_divider_16by8: latency, results, backpressure, reset.
module tb_seq_divider_16by8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        busy;

  int checks;
  int failures;
  int cyc;

  seq_divider_16by8 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Issues one operand pair and waits for out_valid; lat counts clocks from the accept cycle.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b, output int lat,
                       output logic [15:0] q, output logic [7:0] r, output logic z,
                       output bit to);
    int n;
    to = 1'b0;
    n  = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) to = 1'b1;
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        quotient !== 16'h0 || remainder !== 8'h0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got rdy=%b ov=%b busy=%b q=%h r=%h z=%b want 1 0 0 0000 00 0",
               in_ready, out_valid, busy, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset done");
  endtask

  task automatic test_directed();
    logic [15:0] va [7];
    logic [7:0]  vb [7];
    logic [15:0] eq [7];
    logic [7:0]  er [7];
    logic        ez [7];
    int          el [7];
    int lat; logic [15:0] q; logic [7:0] r; logic z; bit to;
    va = '{16'hC350, 16'hFE01, 16'h0064, 16'h1234, 16'hFFFF, 16'h0000, 16'h0003};
    vb = '{8'hC8,    8'hFF,    8'h07,    8'h00,    8'h01,    8'h05,    8'h09};
    eq = '{16'h00FA, 16'h00FF, 16'h000E, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    er = '{8'h00,    8'h00,    8'h02,    8'h34,    8'h00,    8'h00,    8'h03};
    ez = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b0};
    el = '{17,       17,       17,       1,        17,       17,       17};
    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vb[i], lat, q, r, z, to);
      $display("op %h / %h -> q=%h r=%h z=%b lat=%0d", va[i], vb[i], q, r, z, lat);
      checks++;
      if (to || lat != el[i]) begin
        failures++;
        $display("FAIL latency_%0d got %0d want %0d", i, lat, el[i]);
      end
      checks++;
      if (q !== eq[i] || r !== er[i] || z !== ez[i]) begin
        failures++;
        $display("FAIL result_%0d got q=%h r=%h z=%b want q=%h r=%h z=%b",
                 i, q, r, z, eq[i], er[i], ez[i]);
      end
      release_result();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL release_%0d got ov=%b rdy=%b want ov=0 rdy=1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [15:0] q; logic [7:0] r; logic z; bit to;
    int bad;
    do_op(16'h0064, 8'h07, lat, q, r, z, to);
    $display("op 0064 / 07 held under backpressure");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'h000E ||
          remainder !== 8'h02 || div_by_zero !== 1'b0) bad++;
    end
    checks++;
    if (to || bad != 0) begin
      failures++;
      $display("FAIL backpressure_hold got %0d unstable cycles (timeout=%b) want 0", bad, to);
    end
    release_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] q; logic [7:0] r; logic z; bit to;
    dividend = 16'hC350;
    divisor  = 8'hC8;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL busy_before_reset got busy=%b rdy=%b want 1 0", busy, in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        quotient !== 16'h0 || remainder !== 8'h0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got rdy=%b ov=%b busy=%b q=%h r=%h z=%b want 1 0 0 0000 00 0",
               in_ready, out_valid, busy, quotient, remainder, div_by_zero);
    end
    do_op(16'h0005, 8'h03, lat, q, r, z, to);
    $display("op 0005 / 03 after reset -> q=%h r=%h lat=%0d", q, r, lat);
    checks++;
    if (to || lat != 17 || q !== 16'h0001 || r !== 8'h02 || z !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_op got q=%h r=%h z=%b lat=%0d want q=0001 r=02 z=0 lat=17",
               q, r, z, lat);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int first, second, n;
    bit dropped;
    dividend  = 16'h1000;
    divisor   = 8'h10;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    first = cyc;
    @(posedge clk); #1;
    dropped = !out_valid;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    second = cyc;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("back-to-back period %0d cycles q=%h", second - first, quotient);
    checks++;
    if (!dropped || (second - first) != 18) begin
      failures++;
      $display("FAIL throughput got period=%0d dropped=%b want 18 1", second - first, dropped);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; logic [15:0] q; logic [7:0] r; logic z; bit to;
    logic [15:0] a, eq;
    logic [7:0]  b, er;
    int bad;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      b = (i % 97 == 0) ? 8'h00 : 8'($urandom);
      if (b == 8'h00) begin
        eq = 16'hFFFF;
        er = a[7:0];
      end else begin
        eq = a / {8'h00, b};
        er = 8'(a % {8'h00, b});
      end
      do_op(a, b, lat, q, r, z, to);
      if (to || q !== eq || r !== er || z !== (b == 8'h00) ||
          lat != ((b == 8'h00) ? 1 : 17) ||
          (b != 8'h00 && ((32'(q) * 32'(b) + 32'(r)) != 32'(a) || r >= b))) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random_%0d %h / %h got q=%h r=%h z=%b lat=%0d want q=%h r=%h",
                   i, a, b, q, r, z, lat, eq, er);
      end
      release_result();
    end
    $display("random 2000 ops, %0d bad", bad);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL random_total got %0d bad ops want 0", bad);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
